// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scan controller: FSM state codes,
// the all-off patterns and the active-low hex segment table.
package seg_scan_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHOW  = 2'd1;
  localparam state_t ST_BLANK = 2'd2;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0]            SEG_OFF = 7'b1111111;
  localparam logic [MAX_DIGITS-1:0] AN_OFF  = '1;

  // Index 15 first; bit order {a,b,c,d,e,f,g}, a low lights the segment.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };

endpackage

// File: rtl/seg_scan_ctrl_decoder.sv
// Combinational hex-to-seven-segment decoder, outputs active-low {a..g}.
module seven_decoder
  import seg_scan_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_LUT[i_hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode seven-segment display with
// frame-aligned commit. Optional leading-zero blanking: SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter  int NUM_DIGITS   = 4,
  parameter  int REFRESH_DIV  = 50000,
  parameter  int BLANK_CYCLES = 64,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IW-1:0]           digit_idx,
  output logic [1:0]              o_state
);

  localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = ($clog2(MAXC) > 0) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0]         SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] W_AN_OFF   = AN_OFF[NUM_DIGITS-1:0];

  state_t                  r_state, w_state_nx;
  logic [CW-1:0]           r_cnt, w_cnt_nx;
  logic [IW-1:0]           r_idx, w_idx_nx;
  logic                    w_blank_exit, w_commit;

  logic [4*NUM_DIGITS-1:0] r_pend_val, r_disp_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp, r_disp_dp;
  logic                    r_pend_v;

  logic [NUM_DIGITS-1:0]   r_an, w_an_sel, w_lz;
  logic [6:0]              r_seg, w_seg_dec;
  logic                    r_dp_n, w_dp_sel, w_lz_sel;
  logic [IW-1:0]           r_digit_idx;
  logic [3:0]              w_nib;

  // Handshake: a word transfers on a rising clk edge where load_valid and
  // load_ready are both high; the source holds value_in/dp_in until then.
  assign load_ready = ~r_pend_v;
  assign seg        = r_seg;
  assign dp_n       = r_dp_n;
  assign an         = r_an;
  assign digit_idx  = r_digit_idx;
  assign o_state    = r_state;

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt + CW'(1);
    w_idx_nx     = r_idx;
    w_blank_exit = 1'b0;
    if (!enable) begin
      w_state_nx = ST_IDLE;
      w_cnt_nx   = '0;
      w_idx_nx   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nx = ST_SHOW;
          w_cnt_nx   = '0;
          w_idx_nx   = '0;
        end
        ST_SHOW: begin
          if (r_cnt == SHOW_LAST) begin
            w_state_nx = ST_BLANK;
            w_cnt_nx   = '0;
          end
        end
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_nx   = ST_SHOW;
            w_cnt_nx     = '0;
            w_blank_exit = 1'b1;
            w_idx_nx     = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = '0;
          w_idx_nx   = '0;
        end
      endcase
    end
  end

  // Only a frame wrap or idle time may swap the displayed value, so no digit tears.
  assign w_commit = r_pend_v &&
                    ((r_state == ST_IDLE) || (w_blank_exit && (r_idx == IDX_LAST)));

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic w_zero_run;
  always_comb begin
    w_lz       = '0;
    w_zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      w_zero_run = w_zero_run & (r_disp_val[4*k +: 4] == 4'h0);
      w_lz[k]    = w_zero_run & ~r_disp_dp[k];
    end
  end
`else
  assign w_lz = '0;
`endif

  always_comb begin
    w_nib    = 4'h0;
    w_dp_sel = 1'b0;
    w_lz_sel = 1'b0;
    w_an_sel = W_AN_OFF;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_nib       = r_disp_val[4*k +: 4];
        w_dp_sel    = r_disp_dp[k];
        w_lz_sel    = w_lz[k];
        w_an_sel[k] = 1'b0;
      end
    end
  end

  seven_decoder u_dec (
    .i_hex (w_nib),
    .o_seg (w_seg_dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_pend_v   <= 1'b0;
      r_disp_val <= '0;
      r_disp_dp  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      if (w_commit) begin
        r_disp_val <= r_pend_val;
        r_disp_dp  <= r_pend_dp;
        r_pend_v   <= 1'b0;
      end else if (load_valid && !r_pend_v) begin
        r_pend_val <= value_in;
        r_pend_dp  <= dp_in;
        r_pend_v   <= 1'b1;
      end
    end
  end

  // Pin drivers are registered from the current state; enable low darkens them at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an        <= W_AN_OFF;
      r_seg       <= SEG_OFF;
      r_dp_n      <= 1'b1;
      r_digit_idx <= '0;
    end else begin
      r_digit_idx <= enable ? r_idx : '0;
      if (enable && (r_state == ST_SHOW) && !w_lz_sel) begin
        r_an   <= w_an_sel;
        r_seg  <= w_seg_dec;
        r_dp_n <= ~w_dp_sel;
      end else begin
        r_an   <= W_AN_OFF;
        r_seg  <= SEG_OFF;
        r_dp_n <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: table of load/scan vectors plus hand-written
// sequences for reset, mid-frame load, held valid and enable drop.
module tb_seg_scan_ctrl;

  localparam logic [1:0] TB_IDLE  = 2'd0;
  localparam logic [1:0] TB_SHOW  = 2'd1;
  localparam logic [1:0] TB_BLANK = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load_valid;
  logic        load_ready;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic [1:0]  o_state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int hs       = 0;
  logic xfer_pending;

  typedef struct {
    logic [15:0]     val;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic [3:0][6:0] seg;
  } vec_t;

  vec_t vecs[7];

  seg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .seg        (seg),
    .dp_n       (dp_n),
    .an         (an),
    .digit_idx  (digit_idx),
    .o_state    (o_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_digit(input string tag, input int d, input logic [6:0] exp_seg,
                             input logic exp_dpn, input logic [3:0] exp_an);
    check($sformatf("%s d%0d an", tag, d), {28'h0, an}, {28'h0, exp_an});
    check($sformatf("%s d%0d seg", tag, d), {25'h0, seg}, {25'h0, exp_seg});
    check($sformatf("%s d%0d dp_n", tag, d), {31'h0, dp_n}, {31'h0, exp_dpn});
    check($sformatf("%s d%0d idx", tag, d), {30'h0, digit_idx}, d);
  endtask

  task automatic load_idle(input logic [15:0] v, input logic [3:0] d);
    value_in   = v;
    dp_in      = d;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  task set_vec(input int i, input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
               input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
               input logic [6:0] s0);
    vecs[i].val    = v;
    vecs[i].dp     = d;
    vecs[i].blank  = b;
    vecs[i].seg[3] = s3;
    vecs[i].seg[2] = s2;
    vecs[i].seg[1] = s1;
    vecs[i].seg[0] = s0;
  endtask

  initial begin
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dpn;

    set_vec(0, 16'h3210, 4'b0000, 4'b0000, 7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001);
    set_vec(1, 16'h7654, 4'b1010, 4'b0000, 7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100);
    set_vec(2, 16'hBA98, 4'b0000, 4'b0000, 7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000);
    set_vec(3, 16'hFEDC, 4'b1111, 4'b0000, 7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001);
    set_vec(4, 16'h12AF, 4'b0100, 4'b0000, 7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    set_vec(5, 16'h0050, 4'b0000, 4'b1100, 7'b1111111, 7'b1111111, 7'b0100100, 7'b0000001);
    set_vec(6, 16'h0000, 4'b0000, 4'b1110, 7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001);
`else
    set_vec(5, 16'h0050, 4'b0000, 4'b0000, 7'b0000001, 7'b0000001, 7'b0100100, 7'b0000001);
    set_vec(6, 16'h0000, 4'b0000, 4'b0000, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001);
`endif

    reset        = 1'b1;
    enable       = 1'b0;
    value_in     = '0;
    dp_in        = '0;
    load_valid   = 1'b0;
    xfer_pending = 1'b0;
    run(2);
    check("reset an", {28'h0, an}, 32'hF);
    check("reset seg", {25'h0, seg}, 32'h7F);
    check("reset dp_n", {31'h0, dp_n}, 32'h1);
    check("reset idx", {30'h0, digit_idx}, 32'h0);
    check("reset load_ready", {31'h0, load_ready}, 32'h1);
    check("reset state", {30'h0, o_state}, {30'h0, TB_IDLE});
    reset = 1'b0;
    run(2);

    // Table: load while idle, then scan one full frame.
    for (int v = 0; v < 7; v++) begin
      load_idle(vecs[v].val, vecs[v].dp);
      check($sformatf("vec%0d ready after load", v), {31'h0, load_ready}, 32'h0);
      step();
      check($sformatf("vec%0d ready after commit", v), {31'h0, load_ready}, 32'h1);
      enable = 1'b1;
      run(2);
      for (int d = 0; d < 4; d++) begin
        run(3);
        exp_an  = vecs[v].blank[d] ? 4'hF : (4'hF ^ (4'h1 << d));
        exp_seg = vecs[v].seg[d];
        exp_dpn = vecs[v].blank[d] ? 1'b1 : ~vecs[v].dp[d];
        check_digit($sformatf("vec%0d", v), d, exp_seg, exp_dpn, exp_an);
        run(7);
      end
      enable = 1'b0;
      run(2);
    end

    // Reset asserted mid-SHOW with a load pending, then restart timing.
    enable = 1'b1;
    run(15);
    load_idle(16'h9999, 4'b0000);
    check("pre-reset ready low", {31'h0, load_ready}, 32'h0);
    reset = 1'b1;
    #1;
    check("async reset an", {28'h0, an}, 32'hF);
    check("async reset seg", {25'h0, seg}, 32'h7F);
    check("async reset ready", {31'h0, load_ready}, 32'h1);
    step();
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      exp_an = ((i >= 2) && (i <= 9)) ? 4'b1110 : ((i == 12) ? 4'b1101 : 4'b1111);
      check($sformatf("restart cyc%0d an", i), {28'h0, an}, {28'h0, exp_an});
    end
    enable = 1'b0;
    run(2);

    // Mid-frame load, then a second load held while the buffer is full.
    load_idle(16'h12AF, 4'b0100);
    step();
    enable = 1'b1;
    cyc    = 0;
    for (int k = 1; k <= 90; k++) begin
      step();
      if (xfer_pending) begin
        load_valid   = 1'b0;
        xfer_pending = 1'b0;
      end
      if (load_valid && load_ready && (k > 5)) begin
        hs++;
        xfer_pending = 1'b1;
      end
      if (k == 5)  check("midload ready drop", {31'h0, load_ready}, 32'h0);
      if (k == 15) check_digit("old frame", 1, 7'b0001000, 1'b1, 4'b1101);
      if (k == 25) check_digit("old frame", 2, 7'b0010010, 1'b0, 4'b1011);
      if (k == 35) check_digit("old frame", 3, 7'b1001111, 1'b1, 4'b0111);
      if (k == 40) check("ready before wrap", {31'h0, load_ready}, 32'h0);
      if (k == 41) check("ready after wrap", {31'h0, load_ready}, 32'h1);
      if (k == 42) check("held load accepted", {31'h0, load_ready}, 32'h0);
      if (k == 45) check_digit("new frame", 0, 7'b0000000, 1'b1, 4'b1110);
      if (k == 55) check_digit("new frame", 1, 7'b0000001, 1'b1, 4'b1101);
      if (k == 80) check("ready before wrap2", {31'h0, load_ready}, 32'h0);
      if (k == 81) check("ready after wrap2", {31'h0, load_ready}, 32'h1);
      if (k == 85) check_digit("held frame", 0, 7'b1001111, 1'b0, 4'b1110);
      if (k == 86) check("no duplicate load", {31'h0, load_ready}, 32'h1);
      if (k == 4) begin
        value_in   = 16'h0008;
        dp_in      = 4'b0000;
        load_valid = 1'b1;
      end
      if (k == 5) begin
        value_in   = 16'h4321;
        dp_in      = 4'b0001;
        load_valid = 1'b1;
      end
    end
    check("held handshake count", hs, 32'd1);
    enable = 1'b0;
    run(2);

    // Enable dropped during BLANK of digit 2, then re-enabled.
    enable = 1'b1;
    cyc    = 0;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 29) begin
        check("blank2 state", {30'h0, o_state}, {30'h0, TB_BLANK});
        check("blank2 idx", {30'h0, digit_idx}, 32'd2);
        enable = 1'b0;
      end
      if (k == 30) begin
        check("disable an", {28'h0, an}, 32'hF);
        check("disable idx", {30'h0, digit_idx}, 32'd0);
        check("disable state", {30'h0, o_state}, {30'h0, TB_IDLE});
        enable = 1'b1;
      end
      if (k == 31) check("reenable idle an", {28'h0, an}, 32'hF);
      if (k == 32) begin
        check("reenable an", {28'h0, an}, 32'hE);
        check("reenable idx", {30'h0, digit_idx}, 32'd0);
        check("reenable state", {30'h0, o_state}, {30'h0, TB_SHOW});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the board's common-anode multi-digit seven-segment display. It accepts a packed hex value through a ready/valid load port and buffers it. The value commits to the display only at frame boundaries, so no digit tears. The controller cycles digit anodes with a programmable dwell and an anti-ghosting blank gap, and feeds the selected nibble through the hex-to-segment lookup. It sits between the processor's debug/register-view outputs and the FPGA display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8).
REFRESH_DIV, 50000, clk cycles each digit is driven (SHOW dwell), >=2.
BLANK_CYCLES, 64, clk cycles all anodes are off between digits, >=1.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
enable  in  1  scan enable; low forces the display dark.
value_in  in  4*NUM_DIGITS  hex value; nibble k is digit k, digit 0 = least significant.
dp_in  in  NUM_DIGITS  decimal-point request per digit, active-high.
load_valid  in  1  value_in/dp_in valid.
load_ready  out  1  pending buffer free.
seg  out  7  segments {a,b,c,d,e,f,g}, active-low, a = seg[6].
dp_n  out  1  decimal point, active-low.
an  out  NUM_DIGITS  digit anodes, active-low, one-hot-low while SHOW.
digit_idx  out  $clog2(NUM_DIGITS) (min 1)  index of the digit being scanned.

Behaviour:
- Reset values (asynchronous): an all 1, seg 7'b1111111, dp_n 1, digit_idx 0, load_ready 1, state IDLE. Display and pending registers are cleared to 0, and pend_v is 0.
- All outputs are registered and change one cycle after the state/counter update.
- Load handshake:
  - Transfer occurs when load_valid && load_ready.
  - Data goes to the pending register and pend_v is set.
  - load_ready = !pend_v.
  - load_valid held while ready is low is not lost; the source must hold the data.
- Commit: pending is copied to the display register and pend_v is cleared when either:
  - the cycle BLANK exits with digit_idx == NUM_DIGITS-1 (frame wrap), or
  - any cycle in IDLE.
  If commit and a new load coincide, commit wins that cycle. load_ready rises the cycle after commit.
- FSM:
  - IDLE: an all 1, seg all 1. If enable is high, go to SHOW with digit_idx 0 and the counter cleared.
  - SHOW: an[digit_idx] = 0, others 1. seg = decode(display nibble digit_idx). dp_n = !dp[digit_idx]. After REFRESH_DIV cycles, go to BLANK.
  - BLANK: an all 1, seg all 1, dp_n 1. After BLANK_CYCLES cycles, digit_idx = (digit_idx+1) mod NUM_DIGITS, then go to SHOW.
- Dwell counter width: $clog2(max(REFRESH_DIV,BLANK_CYCLES)). It clears on every state change, with no overflow or wrap inside a state.
- enable falling in any state: IDLE next cycle, display dark, digit_idx reset to 0.
- Decode table (abcdefg, active-low):
  - 0 0000001, 1 1001111, 2 0010010, 3 0000110
  - 4 1001100, 5 0100100, 6 0100000, 7 0001111
  - 8 0000000, 9 0000100, A 0001000, b 1100000
  - C 0110001, d 1000010, E 0110000, F 0111000
- NUM_DIGITS=1: digit_idx is constant 0; commit happens every BLANK exit.

Optional Feature:
SEG_LEADING_ZERO_BLANK_EN.
- Defined: a digit k>0 whose committed nibble and every higher nibble are 0, and whose dp bit is 0, is treated as blank. Its anode stays high through SHOW and dwell timing is unchanged. Digit 0 always displays.
- Undefined: every digit displays its nibble, including leading zeros.

Decomposition:
- Package seg_scan_pkg:
  - state enum {IDLE, SHOW, BLANK}
  - SEG_OFF = 7'b1111111
  - AN_OFF (all ones) helper
  - the 16-entry active-low segment constant table
- Sub-module: the existing combinational hex-to-segment decoder seven_decoder (4-bit in, a..g out, active-low) is instantiated once on the muxed nibble.
- All sequencing stays in seg_scan_ctrl.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2):
1. Reset asserted mid-SHOW -> same cycle an=4'b1111, seg=7'b1111111, load_ready=1. After release with enable=1: an=4'b1110 for 8 cycles, then 4'b1111 for 2 cycles, then 4'b1101.
2. Enable high, load 16'h12AF, dp_in=4'b0100 while idle -> committed. Scan shows:
   - digit0 seg=0111000 (F)
   - digit1 0001000 (A)
   - digit2 0010010 (2), dp_n=0
   - digit3 1001111 (1)
   Period per digit is 10 cycles.
3. Mid-frame load 16'h0008 -> load_ready drops next cycle. Digits 1..3 still show the old value. New value appears from digit 0 of the next frame; load_ready returns high one cycle after the wrap.
4. Second load_valid held while load_ready=0 -> no transfer until after commit; the held data is then accepted exactly once.
5. enable dropped during BLANK of digit 2 -> next cycle IDLE, an=1111, digit_idx=0. Re-enable -> restarts at digit 0.
6. With SEG_LEADING_ZERO_BLANK_EN, value 16'h0050 -> an[3] and an[2] stay high during their SHOW windows. Digits 1 (5) and 0 (0) display; value 16'h0000 shows only digit 0.
